// File: rtl/music_control_if.sv
// music_control_if: key inputs and datapath control outputs of music_control.
interface music_control_if;
   logic       record_key;
   logic       play_key;
   logic       stop_key;
   logic       clear_key;
   logic       ld_note;
   logic       ld_play;
   logic [3:0] note_counter;
   logic [4:0] note_count;
   logic       full;
   logic       playing;
   logic       beat;
   modport master (
      output record_key, play_key, stop_key, clear_key,
      input  ld_note, ld_play, note_counter, note_count, full, playing, beat
   );
   modport slave (
      input  record_key, play_key, stop_key, clear_key,
      output ld_note, ld_play, note_counter, note_count, full, playing, beat
   );
endinterface

// File: rtl/music_control.sv
// music_control: turns record/play/stop/clear keys into note store and paced playback controls.
module music_control #(
   parameter int TEMPO_DIV = 12500000,
   parameter int CNT_W     = 25,
   parameter bit LOOP      = 1'b1
) (
   input logic            clk,
   input logic            reset,
   music_control_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PLAY, PAUSE, RESTORE} state_t;
   localparam logic [CNT_W-1:0] TOP = CNT_W'(TEMPO_DIV - 1);
   state_t           state_q, state_d;
   logic [3:0]       key_q, key_d, prev_q;
   logic [CNT_W-1:0] tempo_q, tempo_d;
   logic [3:0]       note_counter_q, note_counter_d;
   logic [4:0]       note_count_q, note_count_d;
   logic             ld_note_q, ld_note_d;
   logic             ld_play_q, ld_play_d;
   logic             beat_q, beat_d;
   logic             playing_q, playing_d;
   logic             full_q, full_d;
   logic             rec_e, ply_e, stp_e, clr_e, clear_hit, last;
   assign {rec_e, ply_e, stp_e, clr_e} = key_q & ~prev_q;
   // Stored note k sits at address k mod 16, so the last note matches the truncated count.
   assign last = note_counter_q == note_count_q[3:0];
   always_comb begin
      key_d          = {bus.record_key, bus.play_key, bus.stop_key, bus.clear_key};
      state_d        = state_q;
      tempo_d        = tempo_q;
      note_counter_d = note_counter_q;
      note_count_d   = note_count_q;
      ld_note_d      = 1'b0;
      beat_d         = 1'b0;
      clear_hit      = 1'b0;
      case (state_q)
         IDLE: begin
            if (clr_e) begin
               note_count_d   = '0;
               note_counter_d = '0;
               clear_hit      = 1'b1;
            end else if (ply_e) begin
               if (note_count_q != '0) begin
                  state_d        = PLAY;
                  note_counter_d = 4'd1;
                  tempo_d        = '0;
               end
            end else if (rec_e && !full_q) begin
               ld_note_d    = 1'b1;
               note_count_d = note_count_q + 5'd1;
            end
         end
         PLAY: begin
            if (stp_e) begin
               state_d        = RESTORE;
               note_counter_d = note_count_q[3:0];
            end else if (ply_e) begin
               state_d = PAUSE;
            end else if (tempo_q == TOP) begin
               tempo_d        = '0;
               beat_d         = 1'b1;
               state_d        = (last && !LOOP) ? RESTORE : PLAY;
               note_counter_d = !last ? note_counter_q + 4'd1 : LOOP ? 4'd1 : note_count_q[3:0];
            end else begin
               tempo_d = tempo_q + CNT_W'(1);
            end
         end
         PAUSE: begin
            if (stp_e) begin
               state_d        = RESTORE;
               note_counter_d = note_count_q[3:0];
            end else if (ply_e) begin
               state_d = PLAY;
            end
         end
         default: state_d = IDLE;
      endcase
      ld_play_d = clear_hit || (state_d != IDLE);
      playing_d = state_d == PLAY;
      full_d    = note_count_d[4];
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q        <= IDLE;
         key_q          <= '0;
         prev_q         <= '0;
         tempo_q        <= '0;
         note_counter_q <= '0;
         note_count_q   <= '0;
         ld_note_q      <= 1'b0;
         ld_play_q      <= 1'b0;
         beat_q         <= 1'b0;
         playing_q      <= 1'b0;
         full_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         key_q          <= key_d;
         prev_q         <= key_q;
         tempo_q        <= tempo_d;
         note_counter_q <= note_counter_d;
         note_count_q   <= note_count_d;
         ld_note_q      <= ld_note_d;
         ld_play_q      <= ld_play_d;
         beat_q         <= beat_d;
         playing_q      <= playing_d;
         full_q         <= full_d;
      end
   end
   assign bus.ld_note      = ld_note_q;
   assign bus.ld_play      = ld_play_q;
   assign bus.note_counter = note_counter_q;
   assign bus.note_count   = note_count_q;
   assign bus.full         = full_q;
   assign bus.playing      = playing_q;
   assign bus.beat         = beat_q;
endmodule

// File: tb/tb_music_control.sv
// tb_music_control: two instances (LOOP=1 as "a", LOOP=0 as "b") driven by shared keys and
// compared every cycle against a note-index reference model, plus a vector table and corner sequences.
module tb_music_control;
   localparam int TD = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic rec = 1'b0, ply = 1'b0, stp = 1'b0, clr = 1'b0;
   int   n_chk = 0, n_pass = 0;
   int   n_ldn_a = 0, n_beat_a = 0;
   music_control_if ia();
   music_control_if ib();
   assign ia.record_key = rec;
   assign ia.play_key   = ply;
   assign ia.stop_key   = stp;
   assign ia.clear_key  = clr;
   assign ib.record_key = rec;
   assign ib.play_key   = ply;
   assign ib.stop_key   = stp;
   assign ib.clear_key  = clr;
   music_control #(.TEMPO_DIV(TD), .CNT_W(3), .LOOP(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ia));
   music_control #(.TEMPO_DIV(TD), .CNT_W(3), .LOOP(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ib));
   always #5 clk = ~clk;
   // Model: mode 0 idle, 1 play, 2 pause, 3 restore; ix is the 1-based note being played.
   int   md[2], nn[2], ix[2], el[2], mnc[2];
   bit   mldn[2], mldp[2], mbt[2];
   logic [3:0] p1, p2;
   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         md[i] = 0; nn[i] = 0; ix[i] = 0; el[i] = 0; mnc[i] = 0;
         mldn[i] = 0; mldp[i] = 0; mbt[i] = 0;
      end
      p1 = '0; p2 = '0;
   endtask
   task automatic model_step();
      logic [3:0] e;
      bit er, ep, es, ec, cl;
      if (reset) begin
         model_reset();
         return;
      end
      e = p1 & ~p2;
      {er, ep, es, ec} = e;
      for (int i = 0; i < 2; i++) begin
         mldn[i] = 0; mbt[i] = 0; cl = 0;
         if (md[i] == 0) begin
            if (ec) begin nn[i] = 0; cl = 1; mnc[i] = 0; end
            else if (ep) begin if (nn[i] > 0) begin md[i] = 1; ix[i] = 1; el[i] = 0; end end
            else if (er && nn[i] < 16) begin nn[i]++; mldn[i] = 1; end
         end else if (md[i] == 1) begin
            if (es) md[i] = 3;
            else if (ep) md[i] = 2;
            else begin
               el[i]++;
               if (el[i] == TD) begin
                  el[i] = 0; mbt[i] = 1;
                  if (ix[i] < nn[i]) ix[i]++;
                  else if (i == 0) ix[i] = 1;
                  else md[i] = 3;
               end
            end
         end else if (md[i] == 2) begin
            if (es) md[i] = 3;
            else if (ep) md[i] = 1;
         end else md[i] = 0;
         if (md[i] == 1 || md[i] == 2) mnc[i] = ix[i] % 16;
         else if (md[i] == 3) mnc[i] = nn[i] % 16;
         mldp[i] = (md[i] != 0) || cl;
      end
      p2 = p1;
      p1 = {rec, ply, stp, clr};
   endtask
   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask
   task automatic chk_dut(input string s, input int i, input int ldn, input int ldp, input int nc,
                          input int cnt, input int fl, input int pl, input int bt);
      chk({s, "_ld_note"}, ldn, int'(mldn[i]));
      chk({s, "_ld_play"}, ldp, int'(mldp[i]));
      chk({s, "_note_counter"}, nc, mnc[i]);
      chk({s, "_note_count"}, cnt, nn[i]);
      chk({s, "_full"}, fl, int'(nn[i] == 16));
      chk({s, "_playing"}, pl, int'(md[i] == 1));
      chk({s, "_beat"}, bt, int'(mbt[i]));
      chk({s, "_excl"}, ldn & ldp, 0);
   endtask
   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (ia.ld_note) n_ldn_a++;
      if (ia.beat) n_beat_a++;
      chk_dut("a", 0, ia.ld_note, ia.ld_play, ia.note_counter, ia.note_count, ia.full, ia.playing, ia.beat);
      chk_dut("b", 1, ib.ld_note, ib.ld_play, ib.note_counter, ib.note_count, ib.full, ib.playing, ib.beat);
   endtask
   task automatic press(input logic [3:0] k, input int hold);
      {rec, ply, stp, clr} = k;
      repeat (hold) cyc();
      {rec, ply, stp, clr} = '0;
      repeat (2) cyc();
   endtask
   typedef struct {
      logic rec, ply, stp, clr;
      logic ldn, ldp;
      int   nc, cnt;
      logic pl, bt;
   } vec_t;
   vec_t tbl[28];
   initial begin
      int nc0, b0, l0;
      tbl = '{
         '{1,0,0,0, 0,0,0,0,0,0}, '{1,0,0,0, 1,0,0,1,0,0}, '{0,0,0,0, 0,0,0,1,0,0}, '{1,0,0,0, 0,0,0,1,0,0},
         '{0,0,0,0, 1,0,0,2,0,0}, '{1,0,0,0, 0,0,0,2,0,0}, '{1,0,0,0, 1,0,0,3,0,0}, '{1,0,0,0, 0,0,0,3,0,0},
         '{0,1,0,0, 0,0,0,3,0,0}, '{0,1,0,0, 0,1,1,3,1,0}, '{0,0,0,0, 0,1,1,3,1,0}, '{0,0,0,0, 0,1,1,3,1,0},
         '{0,0,0,0, 0,1,1,3,1,0}, '{0,0,0,0, 0,1,2,3,1,1}, '{0,0,0,0, 0,1,2,3,1,0}, '{0,0,0,0, 0,1,2,3,1,0},
         '{0,0,0,0, 0,1,2,3,1,0}, '{0,0,0,0, 0,1,3,3,1,1}, '{0,0,0,0, 0,1,3,3,1,0}, '{0,0,0,0, 0,1,3,3,1,0},
         '{0,0,0,0, 0,1,3,3,1,0}, '{0,0,0,0, 0,1,1,3,1,1}, '{0,0,1,0, 0,1,1,3,1,0}, '{0,0,1,0, 0,1,3,3,0,0},
         '{0,0,0,0, 0,0,3,3,0,0}, '{0,0,0,1, 0,0,3,3,0,0}, '{0,0,0,0, 0,1,0,0,0,0}, '{0,0,0,0, 0,0,0,0,0,0}
      };
      model_reset();
      repeat (2) cyc();
      reset = 1'b0;
      chk("rst_note_count", ia.note_count, 0);
      chk("rst_ld_play", ia.ld_play, 0);
      chk("rst_full", ia.full, 0);
      for (int i = 0; i < 28; i++) begin
         {rec, ply, stp, clr} = {tbl[i].rec, tbl[i].ply, tbl[i].stp, tbl[i].clr};
         cyc();
         chk($sformatf("tbl%0d_ld_note", i), ia.ld_note, tbl[i].ldn);
         chk($sformatf("tbl%0d_ld_play", i), ia.ld_play, tbl[i].ldp);
         chk($sformatf("tbl%0d_note_counter", i), ia.note_counter, tbl[i].nc);
         chk($sformatf("tbl%0d_note_count", i), ia.note_count, tbl[i].cnt);
         chk($sformatf("tbl%0d_playing", i), ia.playing, tbl[i].pl);
         chk($sformatf("tbl%0d_beat", i), ia.beat, tbl[i].bt);
      end
      // play and record edges together: play wins, no note stored
      press(4'b1000, 3);
      l0 = n_ldn_a;
      press(4'b1100, 3);
      chk("simul_playing", ia.playing, 1);
      chk("simul_no_ld_note", n_ldn_a - l0, 0);
      chk("simul_count", ia.note_count, 1);
      press(4'b0010, 2);
      press(4'b0001, 2);
      chk("clear_count", ia.note_count, 0);
      // fill to 16 notes, then one refused attempt
      l0 = n_ldn_a;
      repeat (16) press(4'b1000, 10);
      chk("fill_pulses", n_ldn_a - l0, 16);
      chk("fill_full", ia.full, 1);
      l0 = n_ldn_a;
      press(4'b1000, 10);
      chk("17th_no_pulse", n_ldn_a - l0, 0);
      chk("17th_count", ia.note_count, 16);
      chk("17th_full", ia.full, 1);
      // LOOP=0 runs through all 16 notes once and restores to address 0
      press(4'b0100, 1);
      repeat (70) cyc();
      chk("noloop_done", ib.playing, 0);
      chk("noloop_nc", ib.note_counter, 0);
      chk("noloop_ld_play", ib.ld_play, 0);
      chk("loop_still_playing", ia.playing, 1);
      press(4'b0010, 1);
      press(4'b0001, 1);
      repeat (3) press(4'b1000, 10);
      // pause mid-note, hold 20 cycles, resume, then stop
      press(4'b0100, 1);
      cyc();
      press(4'b0100, 1);
      chk("pause_state", ia.playing, 0);
      nc0 = ia.note_counter;
      b0 = n_beat_a;
      repeat (20) cyc();
      chk("pause_nc_held", ia.note_counter, nc0);
      chk("pause_no_beat", n_beat_a - b0, 0);
      chk("pause_ld_play", ia.ld_play, 1);
      press(4'b0100, 1);
      chk("resume_playing", ia.playing, 1);
      repeat (9) cyc();
      stp = 1'b1;
      cyc();
      cyc();
      chk("restore_ld_play", ia.ld_play, 1);
      chk("restore_nc", ia.note_counter, 3);
      chk("restore_playing", ia.playing, 0);
      stp = 1'b0;
      cyc();
      chk("idle_ld_play", ia.ld_play, 0);
      // asynchronous reset in the middle of playback
      press(4'b0100, 1);
      repeat (3) cyc();
      #2 reset = 1'b1;
      #1;
      chk("areset_ld_play", ia.ld_play, 0);
      chk("areset_playing", ia.playing, 0);
      chk("areset_count", ia.note_count, 0);
      chk("areset_nc", ia.note_counter, 0);
      chk("areset_beat", ia.beat, 0);
      model_reset();
      repeat (3) cyc();
      reset = 1'b0;
      cyc();
      chk("post_reset_idle", ia.playing, 0);
      chk("post_reset_ld_play", ia.ld_play, 0);
      // random key activity against the model
      repeat (4000) begin
         if ($urandom_range(0, 3) == 0) rec = ~rec;
         if ($urandom_range(0, 9) == 0) ply = ~ply;
         if ($urandom_range(0, 19) == 0) stp = ~stp;
         if ($urandom_range(0, 39) == 0) clr = ~clr;
         cyc();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
